fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupling instruction queue between the fetch unit and the decode stage.
//  - Captures {instr, pc, pc+4} from fetch and presents them in order to decode.
//  - Uses a valid/ready handshake on both sides.
//  - Absorbs decode stalls without gating the PC register; drops all contents on
//    an E-stage redirect (branch/jal/jalr taken).
// PARAMETERS
//  DEPTH      4              entries; power of 2, >= 2
//  NOP_INSTR  32'h0000_0013  instruction driven on D_instr when no entry is valid (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high reset
//  F_valid        in   1   fetch presents a valid instruction this cycle
//  F_ready        out  1   queue can accept; = (count != DEPTH), registered-state only
//  F_instr        in   32  fetched instruction word
//  F_pc_current   in   32  PC of F_instr
//  F_pc_plus_4    in   32  F_pc_current + 4
//  E_flush        in   1   redirect from execute; discard every queued entry
//  D_valid        out  1   head entry valid for decode
//  D_ready        in   1   decode consumes head this cycle
//  D_instr        out  32  head instruction; NOP_INSTR when !D_valid
//  D_pc           out  32  head PC; 32'h0 when !D_valid
//  D_pc_plus_4    out  32  head PC+4; 32'h0 when !D_valid
//  count          out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  - State: wr_ptr and rd_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0), plus count and storage.
//  - Reset: wr_ptr = rd_ptr = 0, count = 0 -> D_valid = 0, D_* = NOP/0/0, F_ready = 1.
//  - push = F_valid & F_ready & !E_flush. pop = D_valid & D_ready & !E_flush.
//  - count_next = count + push - pop. Simultaneous push and pop keeps count unchanged.
//  - Full (count == DEPTH): F_ready = 0. F_ready never depends on D_ready, so there is
//    no combinational path from D_ready to F_ready.
//  - Empty (count == 0): D_valid = 0 (bypass case excepted). pop is impossible.
//  - Latency: an entry pushed in cycle N is visible on D_* in cycle N+1 (macro off).
//  - Order: strict FIFO; entries never reorder and are never duplicated.
//  - Flush priority:
//    - E_flush = 1 overrides push and pop in the same cycle.
//    - Next cycle: count = 0, rd_ptr = wr_ptr = 0, D_valid = 0.
//    - In the flush cycle itself, D_valid is forced to 0 combinationally.
//  - Reset mid-operation is equivalent to flush. Reset has priority over flush.
//  - Storage content is not reset; D_* are masked to NOP/0/0 whenever !D_valid.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined:
//  - When count == 0 and F_valid & !E_flush: D_valid = 1 and D_* = F_* combinationally.
//  - If D_ready is also 1, the entry passes through and is not written (count stays 0).
//  - If D_ready = 0, the entry is pushed normally.
//  FETCH_QUEUE_BYPASS_EN undefined:
//  - No F->D combinational path; minimum latency is 1 cycle.
// STRUCTURE
//  - fetch_queue_pkg:
//    - typedef struct packed {logic [31:0] instr, pc, pc_plus_4;} fq_entry_t
//    - localparam NOP_INSTR_DEFAULT = 32'h0000_0013
//  - Sub-module fq_storage:
//    - DEPTH x fq_entry_t register array, one write port (we, waddr, wdata)
//    - one async read port (raddr -> rdata)
//  - Top level holds the pointers, count, handshake and masking logic.
// TESTING
//  1 Reset -> count=0, D_valid=0, D_instr=32'h13, F_ready=1.
//  2 Push pc 0x8000_0000/04/08 with D_ready=0 -> count=3.
//    Then D_ready=1 -> D_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, then D_valid=0.
//  3 Push DEPTH entries with D_ready=0 -> F_ready=0 at count=4; an extra F_valid is not accepted.
//    Pop one -> F_ready=1 the next cycle.
//  4 Hold F_valid=D_ready=1 for 10 cycles -> count constant; ptrs wrap past 3.
//    Every pc appears exactly once, in order.
//  5 count=3, E_flush=1 with F_valid=1 and D_ready=1 -> same cycle D_valid=0.
//    Next cycle count=0; the F entry from the flush cycle never appears on D.
//  6 BYPASS_EN, empty, F_valid=1, D_ready=1, F_pc=0x8000_0010 -> same-cycle D_pc=0x8000_0010, count stays 0.
//    Macro off: D_valid rises the next cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
// The optional same-cycle bypass in fetch_queue is enabled by the
// FETCH_QUEUE_BYPASS_EN macro.
package fetch_queue_pkg;

  // One queued fetch record: the instruction, its PC and the precomputed PC+4.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fq_entry_t;

  // addi x0,x0,0 -- what decode sees when nothing valid is at the head.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Bundles the three fetch fields into one entry.
  function automatic fq_entry_t make_entry(input logic [31:0] instr,
                                           input logic [31:0] pc,
                                           input logic [31:0] pc_plus_4);
    fq_entry_t e;
    e.instr     = instr;
    e.pc        = pc;
    e.pc_plus_4 = pc_plus_4;
    return e;
  endfunction

  // The head presented to decode when the queue has nothing valid to show.
  function automatic fq_entry_t idle_entry(input logic [31:0] nop_instr);
    fq_entry_t e;
    e.instr     = nop_instr;
    e.pc        = 32'h0;
    e.pc_plus_4 = 32'h0;
    return e;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry storage for fetch_queue: DEPTH registers, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset;
// the top level masks the head whenever it is not valid.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling instruction queue between fetch and decode.
// Holds {instr, pc, pc+4} records in strict FIFO order behind valid/ready
// handshakes on both sides and drops everything on an execute redirect.
// Define FETCH_QUEUE_BYPASS_EN to let an entry reach decode in the same
// cycle it is fetched when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     F_valid,
  output logic                     F_ready,
  input  logic [31:0]              F_instr,
  input  logic [31:0]              F_pc_current,
  input  logic [31:0]              F_pc_plus_4,
  input  logic                     E_flush,
  output logic                     D_valid,
  input  logic                     D_ready,
  output logic [31:0]              D_instr,
  output logic [31:0]              D_pc,
  output logic [31:0]              D_pc_plus_4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          not_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          store_we;
  logic          store_pop;

  fq_entry_t     f_entry;
  fq_entry_t     rdata;
  fq_entry_t     head;
  fq_entry_t     d_entry;

  assign f_entry   = make_entry(F_instr, F_pc_current, F_pc_plus_4);
  assign not_empty = (count != '0);

  // F_ready looks only at registered occupancy, never at D_ready, so the
  // two handshakes stay free of a combinational loop through the queue.
  assign F_ready = (count != FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !not_empty && F_valid && !E_flush;
`else
  assign bypass = 1'b0;
`endif

  // A redirect hides the head in the cycle it arrives, not just afterwards.
  assign D_valid = (not_empty || bypass) && !E_flush;

  assign push = F_valid && F_ready && !E_flush;
  assign pop  = D_valid && D_ready && !E_flush;

  // A bypassed entry that decode takes immediately is never stored; a
  // bypassed entry that decode stalls on is written like any other push.
  assign store_we  = push && !(bypass && D_ready);
  assign store_pop = pop && not_empty;

  fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (store_we),
    .waddr (wr_ptr),
    .wdata (f_entry),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Choose the head source and mask it to the idle pattern when not valid.
  always_comb begin
    head = rdata;
    if (bypass) begin
      head = f_entry;
    end
    d_entry = idle_entry(NOP_INSTR);
    if (D_valid) begin
      d_entry = head;
    end
  end

  assign D_instr     = d_entry.instr;
  assign D_pc        = d_entry.pc;
  assign D_pc_plus_4 = d_entry.pc_plus_4;

  // Write pointer: advances on every stored entry, cleared by reset or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (E_flush) begin
      wr_ptr <= '0;
    end else if (store_we) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer: advances when decode consumes a stored head.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (E_flush) begin
      rd_ptr <= '0;
    end else if (store_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous store and consume leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (E_flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(store_we) - CW'(store_pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked mid-cycle, well away from the next edge.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        F_valid;
  logic        F_ready;
  logic [31:0] F_instr;
  logic [31:0] F_pc_current;
  logic [31:0] F_pc_plus_4;
  logic        E_flush;
  logic        D_valid;
  logic        D_ready;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc_plus_4;
  logic [2:0]  count;

  int n_compared;
  int n_mismatched;

  fetch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .F_valid      (F_valid),
    .F_ready      (F_ready),
    .F_instr      (F_instr),
    .F_pc_current (F_pc_current),
    .F_pc_plus_4  (F_pc_plus_4),
    .E_flush      (E_flush),
    .D_valid      (D_valid),
    .D_ready      (D_ready),
    .D_instr      (D_instr),
    .D_pc         (D_pc),
    .D_pc_plus_4  (D_pc_plus_4),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch record; instr is derived from the pc so order is traceable.
  task automatic drive_fetch(input logic valid, input logic [31:0] pc);
    F_valid      = valid;
    F_pc_current = pc;
    F_pc_plus_4  = pc + 32'd4;
    F_instr      = {pc[15:0], 16'h0033};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; F_valid = 1'b0; D_ready = 1'b0; E_flush = 1'b0;
    F_instr = '0; F_pc_current = '0; F_pc_plus_4 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_compared++; if (count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_compared++; if (D_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_dvalid: got %b expected 0", D_valid); end
    n_compared++; if (D_instr !== NOP) begin n_mismatched++; $display("[TB] FAIL reset_dinstr: got %h expected %h", D_instr, NOP); end
    n_compared++; if (D_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_dpc: got %h expected 0", D_pc); end
    n_compared++; if (F_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_fready: got %b expected 1", F_ready); end
  endtask

  task automatic test_in_order();
    D_ready = 1'b0;
    drive_fetch(1'b1, 32'h8000_0000);
    tick();
    // Entry pushed last cycle must already be on D.
    n_compared++; if (D_valid !== 1'b1 || D_pc !== 32'h8000_0000) begin n_mismatched++; $display("[TB] FAIL order_latency: got valid=%b pc=%h expected valid=1 pc=80000000", D_valid, D_pc); end
    drive_fetch(1'b1, 32'h8000_0004);
    tick();
    drive_fetch(1'b1, 32'h8000_0008);
    tick();
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (count !== 3'd3) begin n_mismatched++; $display("[TB] FAIL order_count: got %0d expected 3", count); end
    D_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h8000_0000 + 32'(4 * i);
      n_compared++; if (D_valid !== 1'b1 || D_pc !== exp_pc) begin n_mismatched++; $display("[TB] FAIL order_pc%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, D_valid, D_pc, exp_pc); end
      n_compared++; if (D_instr !== {exp_pc[15:0], 16'h0033} || D_pc_plus_4 !== exp_pc + 32'd4) begin n_mismatched++; $display("[TB] FAIL order_data%0d: got instr=%h pc4=%h expected instr=%h pc4=%h", i, D_instr, D_pc_plus_4, {exp_pc[15:0], 16'h0033}, exp_pc + 32'd4); end
      tick();
    end
    n_compared++; if (D_valid !== 1'b0 || D_instr !== NOP || D_pc !== 32'h0 || D_pc_plus_4 !== 32'h0) begin n_mismatched++; $display("[TB] FAIL order_empty: got valid=%b instr=%h pc=%h pc4=%h expected 0/%h/0/0", D_valid, D_instr, D_pc, D_pc_plus_4, NOP); end
    n_compared++; if (count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL order_drained: got %0d expected 0", count); end
    D_ready = 1'b0;
  endtask

  task automatic test_full();
    D_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_fetch(1'b1, 32'h0000_0100 + 32'(4 * i));
      tick();
    end
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (count !== 3'd4) begin n_mismatched++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
    n_compared++; if (F_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_fready: got %b expected 0", F_ready); end
    drive_fetch(1'b1, 32'h0000_0200);
    tick();
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (count !== 3'd4) begin n_mismatched++; $display("[TB] FAIL full_reject: got %0d expected 4", count); end
    D_ready = 1'b1;
    #1;
    n_compared++; if (F_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_no_dready_path: got %b expected 0", F_ready); end
    n_compared++; if (D_pc !== 32'h0000_0100) begin n_mismatched++; $display("[TB] FAIL full_head: got %h expected 00000100", D_pc); end
    tick();
    D_ready = 1'b0;
    #1;
    n_compared++; if (F_ready !== 1'b1 || count !== 3'd3) begin n_mismatched++; $display("[TB] FAIL full_after_pop: got fready=%b count=%0d expected 1/3", F_ready, count); end
    D_ready = 1'b1;
    #1;
    for (int i = 1; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h0000_0100 + 32'(4 * i);
      n_compared++; if (D_valid !== 1'b1 || D_pc !== exp_pc) begin n_mismatched++; $display("[TB] FAIL full_drain%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, D_valid, D_pc, exp_pc); end
      tick();
    end
    n_compared++; if (D_valid !== 1'b0 || count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL full_drained: got valid=%b count=%0d expected 0/0", D_valid, count); end
    D_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    D_ready = 1'b0;
    drive_fetch(1'b1, 32'h0000_0300);
    tick();
    D_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp_pc;
      drive_fetch(1'b1, 32'h0000_0304 + 32'(4 * i));
      exp_pc = 32'h0000_0300 + 32'(4 * i);
      n_compared++; if (D_valid !== 1'b1 || D_pc !== exp_pc) begin n_mismatched++; $display("[TB] FAIL b2b_pc%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, D_valid, D_pc, exp_pc); end
      n_compared++; if (count !== 3'd1) begin n_mismatched++; $display("[TB] FAIL b2b_count%0d: got %0d expected 1", i, count); end
      tick();
    end
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (D_pc !== 32'h0000_0328 || D_pc_plus_4 !== 32'h0000_032c) begin n_mismatched++; $display("[TB] FAIL b2b_last: got pc=%h pc4=%h expected 00000328/0000032c", D_pc, D_pc_plus_4); end
    tick();
    n_compared++; if (D_valid !== 1'b0 || count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL b2b_drained: got valid=%b count=%0d expected 0/0", D_valid, count); end
    D_ready = 1'b0;
  endtask

  task automatic test_flush();
    D_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_fetch(1'b1, 32'h0000_0400 + 32'(4 * i));
      tick();
    end
    n_compared++; if (count !== 3'd3) begin n_mismatched++; $display("[TB] FAIL flush_precount: got %0d expected 3", count); end
    D_ready = 1'b1;
    E_flush = 1'b1;
    drive_fetch(1'b1, 32'h0000_040c);
    n_compared++; if (D_valid !== 1'b0 || D_instr !== NOP || D_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL flush_same_cycle: got valid=%b instr=%h pc=%h expected 0/%h/0", D_valid, D_instr, D_pc, NOP); end
    tick();
    E_flush = 1'b0;
    D_ready = 1'b0;
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (count !== 3'd0 || D_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_next: got count=%0d valid=%b expected 0/0", count, D_valid); end
    drive_fetch(1'b1, 32'h0000_0500);
    tick();
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (D_pc !== 32'h0000_0500 || count !== 3'd1) begin n_mismatched++; $display("[TB] FAIL flush_refill: got pc=%h count=%0d expected 00000500/1", D_pc, count); end
    D_ready = 1'b1;
    tick();
    D_ready = 1'b0;
    #1;
    n_compared++; if (D_valid !== 1'b0 || count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL flush_no_ghost: got valid=%b pc=%h count=%0d expected 0/-/0", D_valid, D_pc, count); end
  endtask

  task automatic test_reset_mid();
    D_ready = 1'b0;
    drive_fetch(1'b1, 32'h0000_0600);
    tick();
    drive_fetch(1'b1, 32'h0000_0604);
    tick();
    reset = 1'b1;
    D_ready = 1'b1;
    drive_fetch(1'b1, 32'h0000_0608);
    tick();
    reset = 1'b0;
    D_ready = 1'b0;
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (count !== 3'd0 || D_valid !== 1'b0 || F_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_mid: got count=%0d valid=%b fready=%b expected 0/0/1", count, D_valid, F_ready); end
  endtask

  task automatic test_bypass();
    D_ready = 1'b1;
    drive_fetch(1'b1, 32'h8000_0010);
`ifdef FETCH_QUEUE_BYPASS_EN
    n_compared++; if (D_valid !== 1'b1 || D_pc !== 32'h8000_0010 || D_instr !== 32'h0010_0033) begin n_mismatched++; $display("[TB] FAIL bypass_same_cycle: got valid=%b pc=%h instr=%h expected 1/80000010/00100033", D_valid, D_pc, D_instr); end
    tick();
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (count !== 3'd0 || D_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bypass_not_stored: got count=%0d valid=%b expected 0/0", count, D_valid); end
`else
    n_compared++; if (D_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nobypass_same_cycle: got valid=%b expected 0", D_valid); end
    tick();
    drive_fetch(1'b0, 32'h0);
    n_compared++; if (D_valid !== 1'b1 || D_pc !== 32'h8000_0010 || count !== 3'd1) begin n_mismatched++; $display("[TB] FAIL nobypass_next: got valid=%b pc=%h count=%0d expected 1/80000010/1", D_valid, D_pc, count); end
    tick();
    n_compared++; if (count !== 3'd0 || D_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nobypass_drain: got count=%0d valid=%b expected 0/0", count, D_valid); end
`endif
    D_ready = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    #1;
    test_reset();
    test_in_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
